// File: rtl/ins_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ins_fetch_pkg
// Description : Shared definitions for the instruction-fetch stage:
//               instruction length, PC step, FSM state encoding and the
//               per-entry fault/interrupt tag record.
// Revision    : 1.0 - initial release
// ============================================================================
package ins_fetch_pkg;

    localparam int          ILEN    = 32;
    localparam int unsigned PC_STEP = 4;

    // Fetch FSM encoding
    localparam int          STATE_W  = 2;
    localparam logic [1:0]  ST_ISSUE = 2'd0;
    localparam logic [1:0]  ST_WAIT  = 2'd1;
    localparam logic [1:0]  ST_KILL  = 2'd2;
    localparam logic [1:0]  ST_HALT  = 2'd3;

    // Tag record carried alongside every queued instruction. The full
    // queue entry is {ins[ILEN], pc[IADDR_W], tags}; the PC width is a
    // per-instance parameter, so the entry is packed in the top level.
    typedef struct packed {
        logic acc_fault;
        logic page_fault;
        logic addr_mis;
        logic int_acc;
    } fetch_tags_t;

    localparam int TAGS_W = $bits(fetch_tags_t);

    // True when the entry terminates the fetch stream
    function automatic logic tags_fault(input fetch_tags_t t);
        return t.acc_fault | t.page_fault | t.addr_mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Small synchronous FIFO (power-of-two depth) with a
//               synchronous clear. Push and pop may happen in the same
//               cycle; when full, a same-cycle pop frees the slot for the
//               push. The head entry is read straight from storage
//               registers, so data_o has no combinational path from data_i.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               clr_i         - drop all entries (wins over push/pop)
//               push_i/data_i - write an entry
//               pop_i         - remove the head entry
//               data_o        - head entry
//               full_o/empty_o- occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic w_do_pop;
    logic w_do_push;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);
    assign data_o    = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_do_push && !clr_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ins_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ins_fetch
// Description : Instruction-fetch stage. Holds the PC, issues one fetch at
//               a time on the instruction bus and buffers results in a
//               2-entry queue toward ID. Redirects on pipeline flush, tags
//               fetch faults / misalignment and interrupt acceptance on
//               delivered instructions.
// Ports       : clk, rst                - clock, synchronous active-high reset
//               pip_flush, flush_pc     - redirect request and target
//               int_req                 - interrupt pending
//               ibus_req, ibus_addr     - fetch request (held until ack)
//               ibus_ack, ibus_rdata,
//               ibus_acc_fault,
//               ibus_page_fault         - fetch response
//               id_valid, id_ready      - head handshake toward ID
//               id_ins, id_pc, id_*     - head instruction, PC and tags
// Revision    : 1.0 - initial release
// ============================================================================
module ins_fetch
    import ins_fetch_pkg::*;
#(
    parameter int                 IADDR_W  = 32,
    parameter logic [IADDR_W-1:0] RESET_PC = '0,
    parameter int                 QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pip_flush,
    input  logic [IADDR_W-1:0] flush_pc,
    input  logic               int_req,
    output logic               ibus_req,
    output logic [IADDR_W-1:0] ibus_addr,
    input  logic               ibus_ack,
    input  logic [ILEN-1:0]    ibus_rdata,
    input  logic               ibus_acc_fault,
    input  logic               ibus_page_fault,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [ILEN-1:0]    id_ins,
    output logic [IADDR_W-1:0] id_pc,
    output logic               id_acc_fault,
    output logic               id_page_fault,
    output logic               id_addr_mis,
    output logic               id_int_acc
);

    localparam int ENTRY_W = ILEN + IADDR_W + TAGS_W;

    logic [STATE_W-1:0] state_q, state_d;
    logic [IADDR_W-1:0] pc_q, pc_d;
    logic               req_q, req_d;
    logic               kill_q, kill_d;
    logic               int_sticky_q, int_sticky_d;

    logic               w_push;
    logic [ILEN-1:0]    w_push_ins;
    fetch_tags_t        w_push_tags;
    logic [ENTRY_W-1:0] w_push_entry;
    logic [ENTRY_W-1:0] w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_slot_free;
    logic               w_int_tag;
    logic               w_outstanding;
    fetch_tags_t        w_head_tags;

    assign w_pop       = ~w_empty & id_ready;
    // Only ISSUE uses this, where nothing is in flight, so a slot that is
    // free now (or freed by this cycle's pop) is guaranteed at ack time.
    assign w_slot_free = ~w_full | w_pop;
    assign w_int_tag   = int_req & ~int_sticky_q;

    // A bus response is still owed after this cycle: either nothing came
    // back, or what came back was the stale ack being absorbed by kill_q.
    assign w_outstanding = ((state_q == ST_WAIT) || (state_q == ST_KILL)) &&
                           !(ibus_ack && !kill_q);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_d        = req_q;
        kill_d       = kill_q;
        int_sticky_d = int_sticky_q;
        w_push       = 1'b0;
        w_push_ins   = '0;
        w_push_tags  = '0;

        case (state_q)
            ST_ISSUE: begin
                if (w_slot_free) begin
                    if (pc_q[1:0] != 2'b00) begin
                        w_push               = 1'b1;
                        w_push_tags.addr_mis = 1'b1;
                        state_d              = ST_HALT;
                    end else begin
                        req_d   = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (ibus_ack) begin
                    if (kill_q) begin
                        // Late response to a request abandoned by reset;
                        // keep the request up for the real answer.
                        kill_d = 1'b0;
                    end else begin
                        req_d                  = 1'b0;
                        w_push                 = 1'b1;
                        w_push_ins             = ibus_rdata;
                        w_push_tags.acc_fault  = ibus_acc_fault;
                        w_push_tags.page_fault = ibus_page_fault;
                        if (ibus_acc_fault || ibus_page_fault) begin
                            state_d = ST_HALT;
                        end else begin
                            w_push_tags.int_acc = w_int_tag;
                            int_sticky_d        = int_sticky_q | w_int_tag;
                            pc_d                = pc_q + IADDR_W'(PC_STEP);
                            state_d             = ST_ISSUE;
                        end
                    end
                end
            end
            ST_KILL: begin
                if (ibus_ack) begin
                    if (kill_q) begin
                        kill_d = 1'b0;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            default: begin
                // ST_HALT: wait for a redirect
            end
        endcase

        if (pip_flush) begin
            pc_d         = flush_pc;
            req_d        = 1'b0;
            w_push       = 1'b0;
            int_sticky_d = 1'b0;
            state_d      = w_outstanding ? ST_KILL : ST_ISSUE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ISSUE;
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            // An in-flight request at reset still gets an ack from the bus
            kill_q       <= req_q;
            int_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_q        <= req_d;
            kill_q       <= kill_d;
            int_sticky_q <= int_sticky_d;
        end
    end

    assign w_push_entry = {w_push_ins, pc_q, w_push_tags};

    fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (pip_flush),
        .push_i  (w_push),
        .data_i  (w_push_entry),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign ibus_req  = req_q;
    assign ibus_addr = pc_q;

    // Head fields are forced to zero when the queue is empty so stale
    // storage never shows on the ID interface.
    assign w_head_tags   = w_empty ? '0 : fetch_tags_t'(w_head[TAGS_W-1:0]);
    assign id_valid      = ~w_empty;
    assign id_ins        = w_empty ? '0 : w_head[ENTRY_W-1 -: ILEN];
    assign id_pc         = w_empty ? '0 : w_head[TAGS_W +: IADDR_W];
    assign id_acc_fault  = w_head_tags.acc_fault;
    assign id_page_fault = w_head_tags.page_fault;
    assign id_addr_mis   = w_head_tags.addr_mis;
    assign id_int_acc    = w_head_tags.int_acc;

endmodule
`default_nettype wire
